// File: rtl/conv_seq_pkg.sv
// Shared types and default widths for the convolution address sequencer.
package conv_seq_pkg;

    localparam int unsigned DEF_AW = 13;
    localparam int unsigned DEF_CW = 4;
    localparam int unsigned DEF_XW = 5;
    localparam int unsigned DEF_KW = 3;
    localparam int unsigned DEF_SW = 2;

    typedef enum logic [2:0] {
        IDLE,
        KINIT,
        EXEC,
        FIN,
        OUT,
        DONE
    } state_t;

    // Which accumulator the next input address is derived from.
    typedef enum logic [1:0] {
        INC_KX,
        INC_ROW,
        INC_CH
    } inc_sel_t;

endpackage

// File: rtl/conv_win_cnt.sv
// Nested c/ky/kx window counter (kx innermost) for one output pixel.
module conv_win_cnt
    import conv_seq_pkg::*;
#(
    parameter int unsigned CW = DEF_CW,
    parameter int unsigned KW = DEF_KW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr,
    input  logic          i_en,
    input  logic [CW-1:0] i_id,
    input  logic [KW-1:0] i_kh,
    input  logic [KW-1:0] i_kw,
    output logic [KW-1:0] o_ky,
    output logic [KW-1:0] o_kx,
    output logic          o_last_c,
    output inc_sel_t      o_inc_sel_c
);

    logic [CW-1:0] r_c;
    logic [KW-1:0] r_ky;
    logic [KW-1:0] r_kx;
    logic          w_kx_wrap;
    logic          w_ky_wrap;
    logic          w_c_wrap;

    assign w_kx_wrap = (r_kx == i_kw);
    assign w_ky_wrap = (r_ky == i_kh);
    assign w_c_wrap  = (r_c == i_id);
    assign o_last_c  = w_kx_wrap && w_ky_wrap && w_c_wrap;
    assign o_ky      = r_ky;
    assign o_kx      = r_kx;

    always_comb begin
        o_inc_sel_c = INC_KX;
        if (w_kx_wrap) begin
            o_inc_sel_c = w_ky_wrap ? INC_CH : INC_ROW;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_c  <= '0;
            r_ky <= '0;
            r_kx <= '0;
        end else if (i_en) begin
            if (!w_kx_wrap) begin
                r_kx <= r_kx + KW'(1);
            end else begin
                r_kx <= '0;
                if (!w_ky_wrap) begin
                    r_ky <= r_ky + KW'(1);
                end else begin
                    r_ky <= '0;
                    r_c  <= w_c_wrap ? '0 : r_c + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/conv_addr_seq.sv
// Convolution address sequencer: per output pixel, walks the input window then reads back outputs.
// Optional zero-padding bounds logic enabled by defining PAD_EN.
module conv_addr_seq
    import conv_seq_pkg::*;
#(
    parameter int unsigned AW = DEF_AW,
    parameter int unsigned CW = DEF_CW,
    parameter int unsigned XW = DEF_XW,
    parameter int unsigned KW = DEF_KW,
    parameter int unsigned SW = DEF_SW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          hold,
    input  logic [CW-1:0] id,
    input  logic [CW-1:0] od,
    input  logic [XW-1:0] ih,
    input  logic [XW-1:0] iw,
    input  logic [XW-1:0] oh,
    input  logic [XW-1:0] ow,
    input  logic [KW-1:0] kh,
    input  logic [KW-1:0] kw,
    input  logic [SW-1:0] st,
    input  logic [1:0]    pad,
    input  logic [AW-1:0] is,
    input  logic [AW-1:0] os,
    output logic          busy,
    output logic          k_init,
    output logic          exec,
    output logic [AW-1:0] ia,
    output logic          pad_o,
    output logic [AW-1:0] wa,
    output logic          k_fin,
    output logic          outr,
    output logic [CW-1:0] ra,
    output logic [AW-1:0] oa,
    output logic          done
);

    state_t        r_state;
    state_t        w_nstate;
    logic          w_go;
    logic          w_kinit_p;
    logic          w_term;
    logic          w_fin_p;
    logic          w_out;
    logic          w_done_p;
    logic          w_out_last;
    logic          w_pix_last;
    logic          w_pix_adv;
    logic          w_win_last;
    inc_sel_t      w_inc_sel;
    logic [KW-1:0] w_ky;
    logic [KW-1:0] w_kx;
    logic          w_pad_hit;
    logic [1:0]    w_pad;

    logic [XW-1:0] r_ox;
    logic [XW-1:0] r_oy;
    logic [AW-1:0] r_opix;
    logic [AW-1:0] r_in_row;
    logic [AW-1:0] r_in_pix;
    logic [AW-1:0] r_ch_acc;
    logic [AW-1:0] r_row_acc;
    logic [AW-1:0] r_ia;
    logic [AW-1:0] r_wa;
    logic [CW-1:0] r_ra;
    logic [AW-1:0] r_oa;

    logic [AW-1:0] w_colw;
    logic [AW-1:0] w_colstep;
    logic [AW-1:0] w_rowstep;
    logic [AW-1:0] w_padoff;

    // Config-static step sizes; the per-term path below only adds.
    assign w_colw    = AW'(iw) + AW'(1);
    assign w_colstep = AW'(st) + AW'(1);
    assign w_rowstep = w_colstep * w_colw;
    assign w_padoff  = AW'(w_pad) * w_colw + AW'(w_pad);

    assign w_out_last = (r_ra == od);
    assign w_pix_last = (r_ox == ow) && (r_oy == oh);
    assign w_pix_adv  = w_out && w_out_last && !w_pix_last;

    conv_win_cnt #(
        .CW(CW),
        .KW(KW)
    ) u_win (
        .clk         (clk),
        .rst         (rst),
        .i_clr       (w_kinit_p),
        .i_en        (w_term),
        .i_id        (id),
        .i_kh        (kh),
        .i_kw        (kw),
        .o_ky        (w_ky),
        .o_kx        (w_kx),
        .o_last_c    (w_win_last),
        .o_inc_sel_c (w_inc_sel)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nstate;
        end
    end

    // Next state plus one-cycle action strobes; hold suppresses everything.
    always_comb begin
        w_nstate  = r_state;
        w_go      = 1'b0;
        w_kinit_p = 1'b0;
        w_term    = 1'b0;
        w_fin_p   = 1'b0;
        w_out     = 1'b0;
        w_done_p  = 1'b0;
        if (!hold) begin
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        w_go     = 1'b1;
                        w_nstate = KINIT;
                    end
                end
                KINIT: begin
                    w_kinit_p = 1'b1;
                    w_nstate  = EXEC;
                end
                EXEC: begin
                    w_term = 1'b1;
                    if (w_win_last) begin
                        w_nstate = FIN;
                    end
                end
                FIN: begin
                    w_fin_p  = 1'b1;
                    w_nstate = OUT;
                end
                OUT: begin
                    w_out = 1'b1;
                    if (w_out_last) begin
                        w_nstate = w_pix_last ? DONE : KINIT;
                    end
                end
                DONE: begin
                    w_done_p = 1'b1;
                    w_nstate = IDLE;
                end
                default: w_nstate = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ox      <= '0;
            r_oy      <= '0;
            r_opix    <= '0;
            r_in_row  <= '0;
            r_in_pix  <= '0;
            r_ch_acc  <= '0;
            r_row_acc <= '0;
            r_ia      <= '0;
            r_wa      <= '0;
            r_ra      <= '0;
            r_oa      <= '0;
        end else begin
            if (w_go) begin
                r_ox     <= '0;
                r_oy     <= '0;
                r_opix   <= '0;
                r_in_row <= AW'(0) - w_padoff;
                r_in_pix <= AW'(0) - w_padoff;
            end
            if (w_kinit_p) begin
                r_ch_acc  <= r_in_pix;
                r_row_acc <= r_in_pix;
                r_ia      <= r_in_pix;
                r_wa      <= '0;
            end
            if (w_term) begin
                r_wa <= r_wa + AW'(1);
                unique case (w_inc_sel)
                    INC_KX: r_ia <= r_ia + AW'(1);
                    INC_ROW: begin
                        r_row_acc <= r_row_acc + w_colw;
                        r_ia      <= r_row_acc + w_colw;
                    end
                    INC_CH: begin
                        r_ch_acc  <= r_ch_acc + is;
                        r_row_acc <= r_ch_acc + is;
                        r_ia      <= r_ch_acc + is;
                    end
                    default: r_ia <= r_ia;
                endcase
            end
            if (w_fin_p) begin
                r_ra <= '0;
                r_oa <= r_opix;
            end
            if (w_out) begin
                r_ra <= r_ra + CW'(1);
                r_oa <= r_oa + os;
            end
            // Output pixel index doubles as the spatial part of oa.
            if (w_pix_adv) begin
                r_opix <= r_opix + AW'(1);
                if (r_ox == ow) begin
                    r_ox     <= '0;
                    r_oy     <= r_oy + XW'(1);
                    r_in_row <= r_in_row + w_rowstep;
                    r_in_pix <= r_in_row + w_rowstep;
                end else begin
                    r_ox     <= r_ox + XW'(1);
                    r_in_pix <= r_in_pix + w_colstep;
                end
            end
        end
    end

`ifdef PAD_EN
    localparam int unsigned PW = XW + SW + KW + 2;

    logic signed [PW-1:0] r_iy0;
    logic signed [PW-1:0] r_ix0;
    logic signed [PW-1:0] w_iy;
    logic signed [PW-1:0] w_ix;

    assign w_pad = pad;
    assign w_iy  = r_iy0 + $signed(PW'(w_ky));
    assign w_ix  = r_ix0 + $signed(PW'(w_kx));
    assign w_pad_hit = w_iy[PW-1] || w_ix[PW-1]
                    || (w_iy > $signed(PW'(ih)))
                    || (w_ix > $signed(PW'(iw)));

    // Signed window origin of the current pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_iy0 <= '0;
            r_ix0 <= '0;
        end else if (w_go) begin
            r_iy0 <= $signed(PW'(0)) - $signed(PW'(pad));
            r_ix0 <= $signed(PW'(0)) - $signed(PW'(pad));
        end else if (w_pix_adv) begin
            if (r_ox == ow) begin
                r_ix0 <= $signed(PW'(0)) - $signed(PW'(pad));
                r_iy0 <= r_iy0 + $signed(PW'(st)) + $signed(PW'(1));
            end else begin
                r_ix0 <= r_ix0 + $signed(PW'(st)) + $signed(PW'(1));
            end
        end
    end
`else
    logic w_unused_cfg;

    assign w_pad        = 2'b00;
    assign w_pad_hit    = 1'b0;
    assign w_unused_cfg = ^{ih, pad, w_ky, w_kx};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            busy   <= 1'b0;
            k_init <= 1'b0;
            exec   <= 1'b0;
            ia     <= '0;
            pad_o  <= 1'b0;
            wa     <= '0;
            k_fin  <= 1'b0;
            outr   <= 1'b0;
            ra     <= '0;
            oa     <= '0;
            done   <= 1'b0;
        end else begin
            busy   <= (r_state != IDLE);
            k_init <= w_kinit_p;
            exec   <= w_term;
            ia     <= (w_term && !w_pad_hit) ? r_ia : '0;
            pad_o  <= w_term && w_pad_hit;
            wa     <= w_term ? r_wa : '0;
            k_fin  <= w_fin_p;
            outr   <= w_out;
            ra     <= w_out ? r_ra : '0;
            oa     <= w_out ? r_oa : '0;
            done   <= w_done_p;
        end
    end

endmodule

// File: tb/tb_conv_addr_seq.sv
// Directed bench for conv_addr_seq; the padding case switches with PAD_EN.
module tb_conv_addr_seq;

    localparam int unsigned AW = 13;
    localparam int unsigned CW = 4;
    localparam int unsigned XW = 5;
    localparam int unsigned KW = 3;
    localparam int unsigned SW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          hold;
    logic [CW-1:0] id;
    logic [CW-1:0] od;
    logic [XW-1:0] ih;
    logic [XW-1:0] iw;
    logic [XW-1:0] oh;
    logic [XW-1:0] ow;
    logic [KW-1:0] kh;
    logic [KW-1:0] kw;
    logic [SW-1:0] st;
    logic [1:0]    pad;
    logic [AW-1:0] is;
    logic [AW-1:0] os;
    logic          busy;
    logic          k_init;
    logic          exec;
    logic [AW-1:0] ia;
    logic          pad_o;
    logic [AW-1:0] wa;
    logic          k_fin;
    logic          outr;
    logic [CW-1:0] ra;
    logic [AW-1:0] oa;
    logic          done;

    always #5 clk = ~clk;

    conv_addr_seq #(
        .AW(AW), .CW(CW), .XW(XW), .KW(KW), .SW(SW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .hold(hold),
        .id(id), .od(od), .ih(ih), .iw(iw), .oh(oh), .ow(ow),
        .kh(kh), .kw(kw), .st(st), .pad(pad), .is(is), .os(os),
        .busy(busy), .k_init(k_init), .exec(exec), .ia(ia), .pad_o(pad_o),
        .wa(wa), .k_fin(k_fin), .outr(outr), .ra(ra), .oa(oa), .done(done)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [AW-1:0] q_ia[$];
    logic [AW-1:0] q_wa[$];
    logic          q_pad[$];
    logic [CW-1:0] q_ra[$];
    logic [AW-1:0] q_oa[$];
    int            q_ecyc[$];
    int            n_init, n_fin, n_done;
    int            c_init0, c_fin0, c_done, c_lastout;
    int            timed_out;
    logic          rst_busy, rst_outr;

    logic [AW-1:0] exp_ia1[9];
    logic          exp_pad4[9];

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input int c_id, input int c_od, input int c_ih, input int c_iw,
                           input int c_oh, input int c_ow, input int c_kh, input int c_kw,
                           input int c_st, input int c_pad, input int c_is, input int c_os);
        id  = CW'(c_id);  od = CW'(c_od);
        ih  = XW'(c_ih);  iw = XW'(c_iw);
        oh  = XW'(c_oh);  ow = XW'(c_ow);
        kh  = KW'(c_kh);  kw = KW'(c_kw);
        st  = SW'(c_st);  pad = 2'(c_pad);
        is  = AW'(c_is);  os = AW'(c_os);
    endtask

    // Start one sequence and record every observed output event, sampled on negedge.
    task automatic run_seq(input int hold_after, input bit rst_on_outr);
        int  hrem;
        bit  held;
        int  post;
        hrem = 0; held = 1'b0; post = 0;
        q_ia.delete(); q_wa.delete(); q_pad.delete();
        q_ra.delete(); q_oa.delete(); q_ecyc.delete();
        n_init = 0; n_fin = 0; n_done = 0;
        c_init0 = -1; c_fin0 = -1; c_done = -1; c_lastout = -1;
        timed_out = 1; rst_busy = 1'bx; rst_outr = 1'bx;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (k_init) begin
                if (c_init0 < 0) c_init0 = cyc;
                n_init++;
            end
            if (exec) begin
                q_ia.push_back(ia); q_wa.push_back(wa);
                q_pad.push_back(pad_o); q_ecyc.push_back(cyc);
            end
            if (k_fin) begin
                if (c_fin0 < 0) c_fin0 = cyc;
                n_fin++;
            end
            if (outr) begin
                q_ra.push_back(ra); q_oa.push_back(oa); c_lastout = cyc;
            end
            if (done) begin
                n_done++; c_done = cyc;
            end
            if (post > 0) begin
                if (post == 1) begin
                    rst_busy = busy; rst_outr = outr; rst = 1'b0;
                end
                post++;
                if (post > 20) begin
                    timed_out = 0;
                    break;
                end
            end else if (rst_on_outr && outr) begin
                rst = 1'b1; post = 1;
            end else if (done && !rst_on_outr) begin
                timed_out = 0;
                break;
            end
            if (hold_after > 0 && !held && exec && q_ia.size() == hold_after) begin
                hold = 1'b1; hrem = 3; held = 1'b1;
            end else if (hrem > 0) begin
                hrem--;
                if (hrem == 0) hold = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        exp_ia1  = '{13'd0, 13'd1, 13'd2, 13'd4, 13'd5, 13'd6, 13'd8, 13'd9, 13'd10};
        exp_pad4 = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        rst = 1'b1; start = 1'b0; hold = 1'b0;
        set_cfg(0, 0, 3, 3, 1, 1, 2, 2, 0, 0, 16, 4);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_exec", int'(exec), 0);
        chk("rst_ia", int'(ia), 0);
        chk("rst_outr", int'(outr), 0);
        chk("rst_done", int'(done), 0);
        rst = 1'b0;

        // 4x4 input, 3x3 kernel, 2x2 output
        run_seq(0, 1'b0);
        chk("t1_timeout", timed_out, 0);
        chk("t1_nterms", q_ia.size(), 36);
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("t1_ia%0d", i), int'(q_ia[i]), int'(exp_ia1[i]));
            chk($sformatf("t1_wa%0d", i), int'(q_wa[i]), i);
        end
        chk("t1_pix1_ia", int'(q_ia[9]), 1);
        chk("t1_pix2_ia", int'(q_ia[18]), 4);
        chk("t1_pix3_ia", int'(q_ia[27]), 5);
        chk("t1_pix1_wa", int'(q_wa[9]), 0);
        chk("t1_exec_span", q_ecyc[8] - q_ecyc[0], 8);
        chk("t1_kinit_lead", q_ecyc[0] - c_init0, 1);
        chk("t1_kfin_lag", c_fin0 - q_ecyc[8], 1);
        chk("t1_ninit", n_init, 4);
        chk("t1_nfin", n_fin, 4);
        chk("t1_ndone", n_done, 1);
        chk("t1_nout", q_oa.size(), 4);
        chk("t1_oa3", int'(q_oa[3]), 3);
        chk("t1_done_lag", c_done - c_lastout, 1);
        @(negedge clk);
        chk("t1_busy_after", int'(busy), 0);

        // two output channels, os=4
        set_cfg(0, 1, 3, 3, 1, 1, 2, 2, 0, 0, 16, 4);
        run_seq(0, 1'b0);
        chk("t2_timeout", timed_out, 0);
        chk("t2_nout", q_oa.size(), 8);
        chk("t2_ra0", int'(q_ra[0]), 0);
        chk("t2_ra1", int'(q_ra[1]), 1);
        chk("t2_oa1", int'(q_oa[1]), 4);
        chk("t2_ra6", int'(q_ra[6]), 0);
        chk("t2_oa6", int'(q_oa[6]), 3);
        chk("t2_oa7", int'(q_oa[7]), 7);

        // 5x5 input, stride 2
        set_cfg(0, 0, 4, 4, 1, 1, 2, 2, 1, 0, 32, 4);
        run_seq(0, 1'b0);
        chk("t3_timeout", timed_out, 0);
        chk("t3_ia3", int'(q_ia[3]), 5);
        chk("t3_pix1_ia", int'(q_ia[9]), 2);
        chk("t3_pix2_ia", int'(q_ia[18]), 10);

        // 3x3 input, 3x3 kernel, pad 1, 3x3 output
        set_cfg(0, 0, 2, 2, 2, 2, 2, 2, 0, 1, 16, 9);
        run_seq(0, 1'b0);
        chk("t4_timeout", timed_out, 0);
        chk("t4_nterms", q_ia.size(), 81);
`ifdef PAD_EN
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("t4_pad%0d", i), int'(q_pad[i]), int'(exp_pad4[i]));
        end
        chk("t4_ia0", int'(q_ia[0]), 0);
        chk("t4_ia4", int'(q_ia[4]), 0);
        chk("t4_ia5", int'(q_ia[5]), 1);
        chk("t4_ia7", int'(q_ia[7]), 3);
        chk("t4_wa6", int'(q_wa[6]), 6);
`else
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("t4_pad%0d", i), int'(q_pad[i]), 0);
        end
        chk("t4_ia4", int'(q_ia[4]), 4);
        chk("t4_ia8", int'(q_ia[8]), 8);
`endif

        // two input channels, 1x1 kernel
        set_cfg(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16, 4);
        run_seq(0, 1'b0);
        chk("t5_timeout", timed_out, 0);
        chk("t5_nterms", q_ia.size(), 2);
        chk("t5_ia0", int'(q_ia[0]), 0);
        chk("t5_ia1", int'(q_ia[1]), 16);
        chk("t5_wa0", int'(q_wa[0]), 0);
        chk("t5_wa1", int'(q_wa[1]), 1);
        chk("t5_ndone", n_done, 1);

        // hold for 3 cycles after the second term
        set_cfg(0, 0, 3, 3, 1, 1, 2, 2, 0, 0, 16, 4);
        run_seq(2, 1'b0);
        chk("t6_timeout", timed_out, 0);
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("t6_ia%0d", i), int'(q_ia[i]), int'(exp_ia1[i]));
        end
        chk("t6_gap01", q_ecyc[1] - q_ecyc[0], 1);
        chk("t6_gap12", q_ecyc[2] - q_ecyc[1] - 1, 3);
        chk("t6_gap23", q_ecyc[3] - q_ecyc[2], 1);
        chk("t6_ndone", n_done, 1);

        // reset during the output readback
        set_cfg(0, 1, 3, 3, 1, 1, 2, 2, 0, 0, 16, 4);
        run_seq(0, 1'b1);
        chk("t7_timeout", timed_out, 0);
        chk("t7_busy", int'(rst_busy), 0);
        chk("t7_outr", int'(rst_outr), 0);
        chk("t7_ndone", n_done, 0);
        chk("t7_nout", q_oa.size(), 1);

        // fresh run after the abort
        set_cfg(0, 0, 3, 3, 1, 1, 2, 2, 0, 0, 16, 4);
        run_seq(0, 1'b0);
        chk("t8_timeout", timed_out, 0);
        chk("t8_ia4", int'(q_ia[4]), 5);
        chk("t8_ndone", n_done, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
